// File: rtl/nlm_cfg_pkg.sv
// Shared constants, reset defaults and FSM state type for the NLM config master.
package nlm_cfg_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int CFG_WIDTH  = 16;
    localparam int CFG_DEPTH  = 2 ** ADDR_WIDTH;

    // Index 0 is the rightmost element.
    localparam logic [CFG_DEPTH-1:0][CFG_WIDTH-1:0] NLM_CFG_DEFAULT = {
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0002, 16'h0005, 16'h0040
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/nlm_cfg_prio_enc.sv
// Lowest-set-bit encoder over the dirty vector; purely combinational.
module nlm_cfg_prio_enc #(
    parameter int W = 3
) (
    input  logic [2**W-1:0] vec_i,
    output logic [W-1:0]    idx_o,
    output logic            any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Descending scan so the lowest set bit is the last assignment.
        for (int i = 2 ** W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/nlm_cfg_master.sv
// Shadow config bank that flushes dirty entries to the NLM block at frame start.
// Optional host readback port enabled by defining NLM_CFG_READBACK_EN.
module nlm_cfg_master
    import nlm_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = nlm_cfg_pkg::ADDR_WIDTH,
    parameter int CFG_WIDTH  = nlm_cfg_pkg::CFG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_wr_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [CFG_WIDTH-1:0]  host_data_i,
    output logic                  host_ready_o,
    input  logic                  commit_i,
    input  logic                  frame_sync_i,
    output logic [ADDR_WIDTH-1:0] config_addr_o,
    output logic [CFG_WIDTH-1:0]  config_data_o,
    output logic                  config_en,
    output logic                  busy_o,
`ifdef NLM_CFG_READBACK_EN
    input  logic [ADDR_WIDTH-1:0] host_raddr_i,
    output logic [CFG_WIDTH-1:0]  host_rdata_o,
`endif
    output logic                  done_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    cfg_state_e            state_q, state_d;
    logic [CFG_WIDTH-1:0]  shadow_q [DEPTH];
    logic [CFG_WIDTH-1:0]  shadow_d [DEPTH];
    logic [DEPTH-1:0]      dirty_q, dirty_d, dirty_w;
    logic                  recommit_q, recommit_d;
    logic [ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CFG_WIDTH-1:0]  cfg_data_q, cfg_data_d;
    logic                  cfg_en_q, cfg_en_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  host_acc;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] pick_idx;
    logic                  pick_any;

    // Picks from the post-write dirty view so a write landing on the
    // frame-start edge is part of the flush it triggers.
    nlm_cfg_prio_enc #(.W(ADDR_WIDTH)) u_prio (
        .vec_i (dirty_w),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        host_acc = host_wr_i && ready_q;
        dirty_w  = dirty_q;
        shadow_d = shadow_q;
        if (host_acc) begin
            dirty_w[host_addr_i]  = 1'b1;
            shadow_d[host_addr_i] = host_data_i;
        end

        state_d    = state_q;
        dirty_d    = dirty_w;
        recommit_d = recommit_q;
        cfg_en_d   = 1'b0;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        done_d     = 1'b0;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (commit_i) state_d = ARMED;
            end
            ARMED: begin
                if (frame_sync_i) begin
                    if (pick_any) begin
                        issue   = 1'b1;
                        state_d = SEND;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            SEND: begin
                recommit_d = recommit_q | commit_i;
                if (pick_any) begin
                    issue = 1'b1;
                end else begin
                    done_d     = 1'b1;
                    state_d    = (recommit_q | commit_i) ? ARMED : IDLE;
                    recommit_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            cfg_en_d          = 1'b1;
            cfg_addr_d        = pick_idx;
            cfg_data_d        = shadow_d[pick_idx];
            dirty_d[pick_idx] = 1'b0;
        end

        busy_d  = (state_d != IDLE);
        // Host stays locked out through the done cycle.
        ready_d = (state_d != SEND) && !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARMED;
            dirty_q    <= '1;
            recommit_q <= 1'b0;
            cfg_en_q   <= 1'b0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= CFG_WIDTH'(NLM_CFG_DEFAULT[i]);
        end else begin
            state_q    <= state_d;
            dirty_q    <= dirty_d;
            recommit_q <= recommit_d;
            cfg_en_q   <= cfg_en_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= shadow_d[i];
        end
    end

`ifdef NLM_CFG_READBACK_EN
    logic [CFG_WIDTH-1:0] rdata_q, rdata_d;

    always_comb rdata_d = shadow_q[host_raddr_i];

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign host_rdata_o = rdata_q;
`else
    // No read port: the shadow bank is write-only from the host side.
`endif

    assign host_ready_o  = ready_q;
    assign config_addr_o = cfg_addr_q;
    assign config_data_o = cfg_data_q;
    assign config_en     = cfg_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_nlm_cfg_master.sv
// Randomized bench for nlm_cfg_master against a snapshot-queue reference model.
module tb_nlm_cfg_master;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_wr_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [DW-1:0] host_data_i = '0;
    logic          commit_i = 1'b0;
    logic          frame_sync_i = 1'b0;
    logic          host_ready_o;
    logic [AW-1:0] config_addr_o;
    logic [DW-1:0] config_data_o;
    logic          config_en;
    logic          busy_o;
    logic          done_o;
`ifdef NLM_CFG_READBACK_EN
    logic [AW-1:0] host_raddr_i = '0;
    logic [DW-1:0] host_rdata_o;
`endif

    nlm_cfg_master dut (
        .clk          (clk),
        .rst          (rst),
        .host_wr_i    (host_wr_i),
        .host_addr_i  (host_addr_i),
        .host_data_i  (host_data_i),
        .host_ready_o (host_ready_o),
        .commit_i     (commit_i),
        .frame_sync_i (frame_sync_i),
        .config_addr_o(config_addr_o),
        .config_data_o(config_data_o),
        .config_en    (config_en),
        .busy_o       (busy_o),
`ifdef NLM_CFG_READBACK_EN
        .host_raddr_i (host_raddr_i),
        .host_rdata_o (host_rdata_o),
`endif
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] defaults [D] = '{16'h0040, 16'h0005, 16'h0002, 16'h0000,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [DW-1:0] m_shadow [D];
    logic [D-1:0]  m_dirty;
    bit            m_pending, m_flushing, m_recommit;
    wr_t           m_q [$];
    logic          e_en, e_done, e_busy, e_ready;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_shadow[i] = defaults[i];
        m_dirty    = '1;
        m_pending  = 1'b1;
        m_flushing = 1'b0;
        m_recommit = 1'b0;
        m_q.delete();
        e_en = 0; e_done = 0; e_busy = 0; e_ready = 0;
        e_addr = '0; e_data = '0; e_rdata = '0;
    endtask

    task automatic model_pop();
        wr_t x;
        x = m_q.pop_front();
        e_en   = 1'b1;
        e_addr = x.a;
        e_data = x.d;
    endtask

    // One clock of behaviour: a frame start snapshots every dirty entry,
    // in address order, into a queue that drains one entry per cycle.
    task automatic model_step(input bit w, input int a, input int d, input bit c,
                              input bit f, input bit r, input int ra);
        wr_t x;
        if (r) begin
            model_reset();
            return;
        end
        e_rdata = m_shadow[ra];
        if (w && e_ready) begin
            m_shadow[a] = d[DW-1:0];
            m_dirty[a]  = 1'b1;
        end
        e_en   = 1'b0;
        e_done = 1'b0;
        if (m_flushing) begin
            if (c) m_recommit = 1'b1;
            if (m_q.size() > 0) model_pop();
            else begin
                e_done     = 1'b1;
                m_flushing = 1'b0;
                m_pending  = m_recommit;
                m_recommit = 1'b0;
            end
        end else if (m_pending) begin
            if (f) begin
                for (int i = 0; i < D; i++) begin
                    if (m_dirty[i]) begin
                        x.a = AW'(i);
                        x.d = m_shadow[i];
                        m_q.push_back(x);
                    end
                end
                m_dirty   = '0;
                m_pending = 1'b0;
                if (m_q.size() == 0) e_done = 1'b1;
                else begin
                    m_flushing = 1'b1;
                    model_pop();
                end
            end
        end else if (c) begin
            m_pending = 1'b1;
        end
        e_ready = !m_flushing && !e_done;
        e_busy  = m_pending || m_flushing;
    endtask

    task automatic step(input bit w, input int a, input int d, input bit c,
                        input bit f, input bit r);
        int ra;
        ra           = $urandom_range(0, D - 1);
        host_wr_i    = w;
        host_addr_i  = a[AW-1:0];
        host_data_i  = d[DW-1:0];
        commit_i     = c;
        frame_sync_i = f;
        rst          = r;
`ifdef NLM_CFG_READBACK_EN
        host_raddr_i = ra[AW-1:0];
`endif
        @(posedge clk);
        model_step(w, a, d, c, f, r, ra);
        #1;
        chk("config_en", 32'(config_en), 32'(e_en));
        chk("config_addr", 32'(config_addr_o), 32'(e_addr));
        chk("config_data", 32'(config_data_o), 32'(e_data));
        chk("done", 32'(done_o), 32'(e_done));
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("host_ready", 32'(host_ready_o), 32'(e_ready));
`ifdef NLM_CFG_READBACK_EN
        chk("host_rdata", 32'(host_rdata_o), 32'(e_rdata));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        // Reset then full default flush
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        idle(11);
        // Sparse commit
        step(1, 5, 'h1234, 0, 0, 0);
        step(1, 2, 'h0003, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        idle(5);
        // Commit with nothing dirty
        step(0, 0, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 1, 0);
        idle(3);
        // Writes during SEND plus recommit
        step(1, 0, 'h1111, 0, 0, 0);
        step(1, 1, 'h2222, 0, 0, 0);
        step(1, 3, 'h3333, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 7, 'h7777, 1, 0, 0);
        idle(5);
        step(0, 0, 0, 0, 1, 0);
        idle(3);
        // Same-cycle commit and frame_sync
        step(1, 4, 'hABCD, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        // Reset mid-flush after the third write
        for (int i = 0; i < D; i++) step(1, i, 'h0100 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        idle(11);
        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, D - 1), $urandom_range(0, 16'hFFFF),
                 $urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 399) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
